// File: rtl/reg_hazard_if.sv
// reg_hazard_if: ID-stage operands, LL return channel and register-file write port of reg_hazard_ctrl.
interface reg_hazard_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_is_load;
    logic        id_is_ll;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        ll_wb_valid;
    logic [4:0]  ll_wb_rd;
    logic        ll_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic        rf_wd_sel;
    logic [31:0] sb_pending;
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
               id_is_load, id_is_ll, flush, ll_wb_valid, ll_wb_rd,
        input  stall, fwd_a_sel, fwd_b_sel, ll_wb_ready, rf_we, rf_wa, rf_wd_sel, sb_pending
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
               id_is_load, id_is_ll, flush, ll_wb_valid, ll_wb_rd,
        output stall, fwd_a_sel, fwd_b_sel, ll_wb_ready, rf_we, rf_wa, rf_wd_sel, sb_pending
    );
endinterface

// File: rtl/reg_hazard_ctrl.sv
// reg_hazard_ctrl: ID->EX->WB hazard/forwarding control, LL scoreboard and regfile write arbitration.
// Define REG_HAZARD_FORWARD_EN to enable EX/WB operand forwarding (otherwise stall on any in-flight match).
module reg_hazard_ctrl #(
    parameter int LL_MAX_PENDING = 4
) (
    input logic         clk,
    input logic         rst,
    reg_hazard_if.slave io_bus
);
    localparam int CW = $clog2(LL_MAX_PENDING + 1);

    logic          r_ex_v, r_ex_we, r_ex_ld, r_ex_ll;
    logic [4:0]    r_ex_rd;
    logic          r_wb_v, r_wb_we, r_wb_ll;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_pending;
    logic [CW-1:0] r_ll_cnt;

    logic       w_a_ex, w_a_wb, w_b_ex, w_b_wb, w_load_use, w_haz;
    logic [1:0] w_fwd_a, w_fwd_b;
    logic       w_stall, w_issue, w_ll_set, w_acc, w_wb_wr;

    function automatic logic hit(input logic used, input logic [4:0] rs, input logic v,
                                 input logic we, input logic ll, input logic [4:0] rd);
        return used && rs != 5'd0 && v && we && !ll && rd == rs;
    endfunction

    assign w_a_ex = hit(io_bus.id_rs1_used, io_bus.id_rs1, r_ex_v, r_ex_we, r_ex_ll, r_ex_rd);
    assign w_a_wb = hit(io_bus.id_rs1_used, io_bus.id_rs1, r_wb_v, r_wb_we, r_wb_ll, r_wb_rd);
    assign w_b_ex = hit(io_bus.id_rs2_used, io_bus.id_rs2, r_ex_v, r_ex_we, r_ex_ll, r_ex_rd);
    assign w_b_wb = hit(io_bus.id_rs2_used, io_bus.id_rs2, r_wb_v, r_wb_we, r_wb_ll, r_wb_rd);
    assign w_load_use = (w_a_ex | w_b_ex) & r_ex_ld;

`ifdef REG_HAZARD_FORWARD_EN
    assign w_haz   = w_load_use;
    assign w_fwd_a = w_a_ex ? 2'd1 : w_a_wb ? 2'd2 : 2'd0;
    assign w_fwd_b = w_b_ex ? 2'd1 : w_b_wb ? 2'd2 : 2'd0;
`else
    assign w_haz   = w_load_use | w_a_ex | w_a_wb | w_b_ex | w_b_wb;
    assign w_fwd_a = 2'd0;
    assign w_fwd_b = 2'd0;
`endif

    // pending[0] is never set, so rs/rd of x0 cannot stall through the scoreboard
    assign w_stall = io_bus.id_valid & !io_bus.flush &
                     ((io_bus.id_rs1_used & r_pending[io_bus.id_rs1]) |
                      (io_bus.id_rs2_used & r_pending[io_bus.id_rs2]) |
                      (io_bus.id_rd_we & r_pending[io_bus.id_rd]) |
                      (io_bus.id_is_ll & r_ll_cnt == CW'(LL_MAX_PENDING)) | w_haz);
    assign w_issue  = io_bus.id_valid & !io_bus.flush & !w_stall;
    assign w_ll_set = w_issue & io_bus.id_is_ll & io_bus.id_rd_we & io_bus.id_rd != 5'd0;
    assign w_wb_wr  = r_wb_v & r_wb_we & !r_wb_ll & r_wb_rd != 5'd0;
    assign w_acc    = io_bus.ll_wb_valid & io_bus.ll_wb_ready;

    assign io_bus.stall       = !rst & w_stall;
    assign io_bus.fwd_a_sel   = rst ? 2'd0 : w_fwd_a;
    assign io_bus.fwd_b_sel   = rst ? 2'd0 : w_fwd_b;
    assign io_bus.ll_wb_ready = !rst & !w_wb_wr;
    assign io_bus.rf_we       = !rst & (w_wb_wr | (io_bus.ll_wb_valid & io_bus.ll_wb_rd != 5'd0));
    assign io_bus.rf_wa       = w_wb_wr ? r_wb_rd : io_bus.ll_wb_rd;
    assign io_bus.rf_wd_sel   = !w_wb_wr;
    assign io_bus.sb_pending  = r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_v    <= 1'b0;
            r_ex_we   <= 1'b0;
            r_ex_ld   <= 1'b0;
            r_ex_ll   <= 1'b0;
            r_ex_rd   <= 5'd0;
            r_wb_v    <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_ll   <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_pending <= 32'd0;
            r_ll_cnt  <= '0;
        end else begin
            r_ex_v    <= w_issue;
            r_ex_we   <= io_bus.id_rd_we;
            r_ex_ld   <= io_bus.id_is_load;
            r_ex_ll   <= io_bus.id_is_ll;
            r_ex_rd   <= io_bus.id_rd;
            r_wb_v    <= r_ex_v;
            r_wb_we   <= r_ex_we;
            r_wb_ll   <= r_ex_ll;
            r_wb_rd   <= r_ex_rd;
            r_pending <= (r_pending & ~(32'(w_acc) << io_bus.ll_wb_rd)) | (32'(w_ll_set) << io_bus.id_rd);
            r_ll_cnt  <= r_ll_cnt + CW'(w_ll_set) - CW'(w_acc);
        end
    end
endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// tb_reg_hazard_ctrl: directed and random issue streams checked against an instruction-history model.
module tb_reg_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_hazard_if bus();
    reg_hazard_ctrl #(.LL_MAX_PENDING(4)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       ll;
    } ins_t;

    localparam int MAXP = 4;
    ins_t       hist[$];
    logic [4:0] ll_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         ll_quiet = 0;
    bit         last_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic u, input logic [4:0] rs, input ins_t s);
        return u && rs != 0 && s.v && s.we && !s.ll && s.rd == rs;
    endfunction

    function automatic bit pend(input logic [4:0] r);
        foreach (ll_q[i]) if (ll_q[i] == r) return 1;
        return 0;
    endfunction

    function automatic ins_t rand_ins();
        ins_t x;
        int k;
        x = '0;
        x.v   = $urandom_range(7, 0) != 0;
        x.rs1 = 5'($urandom_range(7, 0));
        x.rs2 = 5'($urandom_range(7, 0));
        x.u1  = $urandom_range(3, 0) != 0;
        x.u2  = $urandom_range(1, 0) != 0;
        k     = $urandom_range(5, 0);
        x.ld  = k == 3;
        x.ll  = k == 4;
        x.rd  = x.ll ? 5'($urandom_range(7, 1)) : 5'($urandom_range(7, 0));
        x.we  = x.ll || $urandom_range(7, 0) != 0;
        return x;
    endfunction

    task automatic drive(input ins_t in, input bit fl);
        bus.id_valid    = in.v;
        bus.id_rs1      = in.rs1;
        bus.id_rs2      = in.rs2;
        bus.id_rs1_used = in.u1;
        bus.id_rs2_used = in.u2;
        bus.id_rd       = in.rd;
        bus.id_rd_we    = in.we;
        bus.id_is_load  = in.ld;
        bus.id_is_ll    = in.ll;
        bus.flush       = fl;
    endtask

    // One clock: drive ID, predict from the last two issued instructions and outstanding LL list.
    task automatic step(input ins_t in, input bit fl);
        ins_t ex, wb;
        bit ea, wa, eb, wbb, haz, st, wbw, acc;
        logic [1:0] fa, fb;
        logic [31:0] sb;
        drive(in, fl);
        if (!ll_quiet && !bus.ll_wb_valid && ll_q.size() > 0 && $urandom_range(1, 0) == 1) begin
            bus.ll_wb_valid = 1'b1;
            bus.ll_wb_rd    = ll_q[0];
        end
        ex  = hist.size() > 0 ? hist[0] : '0;
        wb  = hist.size() > 1 ? hist[1] : '0;
        ea  = hit(in.u1, in.rs1, ex);
        wa  = hit(in.u1, in.rs1, wb);
        eb  = hit(in.u2, in.rs2, ex);
        wbb = hit(in.u2, in.rs2, wb);
`ifdef REG_HAZARD_FORWARD_EN
        fa  = ea ? 2'd1 : wa ? 2'd2 : 2'd0;
        fb  = eb ? 2'd1 : wbb ? 2'd2 : 2'd0;
        haz = (ea || eb) && ex.ld;
`else
        fa  = 2'd0;
        fb  = 2'd0;
        haz = ea || wa || eb || wbb;
`endif
        st  = in.v && !fl && ((in.u1 && pend(in.rs1)) || (in.u2 && pend(in.rs2)) ||
              (in.we && pend(in.rd)) || (in.ll && ll_q.size() == MAXP) || haz);
        wbw = wb.v && wb.we && !wb.ll && wb.rd != 0;
        sb  = '0;
        foreach (ll_q[i]) sb[ll_q[i]] = 1'b1;
        @(negedge clk);
        chk("stall", 32'(bus.stall), 32'(st));
        chk("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(fa));
        chk("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(fb));
        chk("ll_wb_ready", 32'(bus.ll_wb_ready), 32'(!wbw));
        chk("rf_we", 32'(bus.rf_we), 32'(wbw || (bus.ll_wb_valid && bus.ll_wb_rd != 0)));
        chk("rf_wd_sel", 32'(bus.rf_wd_sel), 32'(!wbw));
        if (wbw) begin
            chk("rf_wa_wb", 32'(bus.rf_wa), 32'(wb.rd));
        end else if (bus.ll_wb_valid) begin
            chk("rf_wa_ll", 32'(bus.rf_wa), 32'(bus.ll_wb_rd));
        end
        chk("sb_pending", bus.sb_pending, sb);
        acc = bus.ll_wb_valid && !wbw;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(ll_q.pop_front());
            bus.ll_wb_valid = 1'b0;
        end
        if (in.v && !fl && !st) begin
            if (in.ll && in.we && in.rd != 0) ll_q.push_back(in.rd);
            hist.push_front(in);
        end else begin
            hist.push_front('0);
        end
        if (hist.size() > 2) void'(hist.pop_back());
        last_stall = st;
    endtask

    task automatic hold(input ins_t in, input int budget);
        for (int k = 0; k < budget; k++) begin
            step(in, 1'b0);
            if (!last_stall) break;
        end
    endtask

    initial begin
        ins_t cur, idle;
        bit fl;
        idle = '0;
        drive('{v: 1'b1, rs1: 5'd5, u1: 1'b1, rd: 5'd6, we: 1'b1, ll: 1'b1, default: '0}, 1'b0);
        bus.ll_wb_valid = 1'b1;
        bus.ll_wb_rd    = 5'd5;
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_fwd_a", 32'(bus.fwd_a_sel), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_ll_ready", 32'(bus.ll_wb_ready), 32'd0);
        chk("rst_sb", bus.sb_pending, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ll_wb_valid = 1'b0;
        bus.ll_wb_rd    = 5'd0;
        step('{v: 1'b1, rd: 5'd5, we: 1'b1, default: '0}, 1'b0);
        hold('{v: 1'b1, rs1: 5'd5, u1: 1'b1, rd: 5'd8, we: 1'b1, default: '0}, 6);
        step('{v: 1'b1, rd: 5'd6, we: 1'b1, ld: 1'b1, default: '0}, 1'b0);
        hold('{v: 1'b1, rs2: 5'd6, u2: 1'b1, rd: 5'd9, we: 1'b1, default: '0}, 6);
        step('{v: 1'b1, rd: 5'd0, we: 1'b1, default: '0}, 1'b0);
        step('{v: 1'b1, rs1: 5'd0, u1: 1'b1, rs2: 5'd0, u2: 1'b1, rd: 5'd0, we: 1'b1, default: '0}, 1'b0);
        step('{v: 1'b1, rd: 5'd7, we: 1'b1, ll: 1'b1, default: '0}, 1'b0);
        hold('{v: 1'b1, rs1: 5'd7, u1: 1'b1, rd: 5'd3, we: 1'b1, default: '0}, 40);
        for (int k = 0; k < 60 && ll_q.size() > 0; k++) step(idle, 1'b0);
        ll_quiet = 1;
        for (int r = 1; r <= 4; r++) step('{v: 1'b1, rd: 5'(r), we: 1'b1, ll: 1'b1, default: '0}, 1'b0);
        step('{v: 1'b1, rd: 5'd5, we: 1'b1, ll: 1'b1, default: '0}, 1'b0);
        chk("ll_full_stall", 32'(bus.stall), 32'd1);
        step('{v: 1'b1, rd: 5'd5, we: 1'b1, ll: 1'b1, default: '0}, 1'b1);
        ll_quiet = 0;
        hold('{v: 1'b1, rd: 5'd5, we: 1'b1, ll: 1'b1, default: '0}, 60);
        cur = rand_ins();
        for (int k = 0; k < 800; k++) begin
            fl = $urandom_range(15, 0) == 0;
            step(cur, fl);
            if (!last_stall || fl) cur = rand_ins();
        end
        ll_quiet = 1;
        step('{v: 1'b1, rd: 5'd1, we: 1'b1, ll: 1'b1, default: '0}, 1'b0);
        step('{v: 1'b1, rs1: 5'd1, u1: 1'b1, rd: 5'd2, we: 1'b1, default: '0}, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_sb", bus.sb_pending, 32'd0);
        chk("midrst_stall", 32'(bus.stall), 32'd0);
        chk("midrst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("midrst_ll_ready", 32'(bus.ll_wb_ready), 32'd0);
        bus.ll_wb_valid = 1'b0;
        hist.delete();
        ll_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ll_quiet = 0;
        cur = rand_ins();
        for (int k = 0; k < 200; k++) begin
            fl = $urandom_range(15, 0) == 0;
            step(cur, fl);
            if (!last_stall || fl) cur = rand_ins();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
